// File: rtl/cpu_pkg.sv
// Shared CPU constants: alu control codes, ALUOp encodings and R-type funct codes.
// The EX-stage alu decodes the same alu_ctrl_e values.
package cpu_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_e;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef struct packed {
      alu_ctrl_e ctrl;
      logic      illegal;
   } alu_decode_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand selector: picks EX/MEM result, then MEM/WB data, then the registered value.
// Register 0 is never forwarded.
module fwd_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] idx,
   input  logic [DATA_W-1:0] reg_val,
   input  logic              exm_regwrite,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              mwb_regwrite,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic [DATA_W-1:0] mwb_data,
   output logic [DATA_W-1:0] fwd_val
);

   always_comb begin
      fwd_val = reg_val;
      if (exm_regwrite && (exm_rd != '0) && (exm_rd == idx))
         fwd_val = exm_result;
      else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == idx))
         fwd_val = mwb_data;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes the alu control, holds the ID/EX register, forwards operands
// into the alu and requests a load-use stall.
module alu_issue_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [1:0]        id_aluop,
   input  logic [5:0]        id_funct,
   input  logic              id_alusrc,
   input  logic              id_regdst,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              stall,
   input  logic              flush,
   input  logic              exm_regwrite,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              mwb_regwrite,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic [DATA_W-1:0] mwb_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_control,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              illegal_op,
   output logic              load_use_stall
);

   function automatic alu_decode_t decode(input logic [1:0] aluop, input logic [5:0] funct);
      alu_decode_t d;
      d.ctrl    = ALU_ADD;
      d.illegal = 1'b0;
      case (aluop_e'(aluop))
         ALUOP_ADD: d.ctrl = ALU_ADD;
         ALUOP_SUB: d.ctrl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: d.ctrl = ALU_ADD;
               FUNCT_SUB: d.ctrl = ALU_SUB;
               FUNCT_AND: d.ctrl = ALU_AND;
               FUNCT_OR:  d.ctrl = ALU_OR;
               FUNCT_SLT: d.ctrl = ALU_SLT;
               default:   d.illegal = 1'b1;
            endcase
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   alu_decode_t       id_dec;
   alu_ctrl_e         ex_ctrl;
   logic              ex_illegal;
   logic              ex_alusrc;
   logic              ex_regwrite_q;
   logic              ex_memread_q;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [DATA_W-1:0] fwd_rt;

   assign id_dec = decode(id_aluop, id_funct);

   // Flush clears only the side-effect flags; data fields hold so a flushed slot stays quiet.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid      <= 1'b0;
         ex_ctrl       <= ALU_ADD;
         ex_illegal    <= 1'b0;
         ex_alusrc     <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_dest       <= '0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_rs_data    <= '0;
         ex_rt_data    <= '0;
         ex_imm        <= '0;
      end else if (flush) begin
         ex_valid      <= 1'b0;
         ex_illegal    <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
      end else if (!stall) begin
         ex_valid      <= id_valid;
         ex_ctrl       <= id_dec.ctrl;
         ex_illegal    <= id_dec.illegal;
         ex_alusrc     <= id_alusrc;
         ex_regwrite_q <= id_regwrite;
         ex_memread_q  <= id_memread;
         ex_dest       <= id_regdst ? id_rd : id_rt;
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_rs_data    <= id_rs_data;
         ex_rt_data    <= id_rt_data;
         ex_imm        <= id_imm;
      end
   end

   assign alu_control = ex_ctrl;
   assign ex_regwrite = ex_regwrite_q & ex_valid;
   assign ex_memread  = ex_memread_q & ex_valid;
   assign illegal_op  = ex_illegal & ex_valid;

   fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .idx(ex_rs), .reg_val(ex_rs_data),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .fwd_val(alu_a)
   );

   fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .idx(ex_rt), .reg_val(ex_rt_data),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .fwd_val(fwd_rt)
   );

   assign alu_b         = ex_alusrc ? ex_imm : fwd_rt;
   assign ex_store_data = fwd_rt;

   assign load_use_stall = id_valid & ex_valid & ex_memread_q & (ex_dest != '0) &
                           ((ex_dest == id_rs) | ((ex_dest == id_rt) & ~id_alusrc));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding, load-use, stall/flush and immediate path.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [1:0]  id_aluop;
   logic [5:0]  id_funct;
   logic        id_alusrc, id_regdst, id_regwrite, id_memread;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        stall, flush;
   logic        exm_regwrite;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        mwb_regwrite;
   logic [4:0]  mwb_rd;
   logic [31:0] mwb_data;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [2:0]  alu_control;
   logic        ex_valid, ex_regwrite, ex_memread, illegal_op, load_use_stall;
   logic [4:0]  ex_dest;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_aluop(id_aluop), .id_funct(id_funct),
      .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .stall(stall), .flush(flush),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_store_data(ex_store_data),
      .illegal_op(illegal_op), .load_use_stall(load_use_stall)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 1'b1; id_aluop = 2'b00; id_funct = '0;
      id_alusrc = 1'b0; id_regdst = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
      id_rs = '0; id_rt = '0; id_rd = '0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0;
      stall = 1'b0; flush = 1'b0;
      exm_regwrite = 1'b0; exm_rd = '0; exm_result = '0;
      mwb_regwrite = 1'b0; mwb_rd = '0; mwb_data = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      id_regwrite = 1'b1; id_memread = 1'b1; id_aluop = 2'b01; id_rt = 5'd3;
      reset = 1'b1;
      step(); step();
      checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
      checks++; if (alu_control !== 3'b010) begin failures++; $display("FAIL reset_ctrl got=%b exp=010", alu_control); end
      checks++; if (ex_regwrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", ex_regwrite); end
      checks++; if (ex_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", ex_dest); end
      checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL reset_lus got=%b exp=0", load_use_stall); end
      reset = 1'b0;
   endtask

   task automatic test_decode();
      logic [1:0] aluops [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
      logic [5:0] functs [8] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27, 6'h24, 6'h20};
      logic [2:0] ctrls  [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b010, 3'b110, 3'b010};
      logic       ills   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      clear_inputs();
      // back-to-back instructions: each result appears exactly one cycle later
      for (int i = 0; i < 8; i++) begin
         id_aluop = aluops[i];
         id_funct = functs[i];
         step();
         checks++; if (alu_control !== ctrls[i]) begin failures++; $display("FAIL decode_ctrl[%0d] got=%b exp=%b", i, alu_control, ctrls[i]); end
         checks++; if (illegal_op !== ills[i]) begin failures++; $display("FAIL decode_illegal[%0d] got=%b exp=%b", i, illegal_op, ills[i]); end
      end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      id_rs = 5'd5; id_rs_data = 32'h1234; id_rt = 5'd6; id_rt_data = 32'h6666;
      step();
      exm_regwrite = 1'b1; exm_rd = 5'd5; exm_result = 32'hAAAA;
      mwb_regwrite = 1'b1; mwb_rd = 5'd5; mwb_data = 32'h5555;
      #1;
      checks++; if (alu_a !== 32'hAAAA) begin failures++; $display("FAIL fwd_exm_prio got=%h exp=0000aaaa", alu_a); end
      checks++; if (alu_b !== 32'h6666) begin failures++; $display("FAIL fwd_b_nomatch got=%h exp=00006666", alu_b); end
      exm_regwrite = 1'b0;
      #1;
      checks++; if (alu_a !== 32'h5555) begin failures++; $display("FAIL fwd_mwb got=%h exp=00005555", alu_a); end
      exm_regwrite = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
      #1;
      checks++; if (alu_a !== 32'h1234) begin failures++; $display("FAIL fwd_r0 got=%h exp=00001234", alu_a); end
      exm_rd = 5'd6;
      #1;
      checks++; if (alu_b !== 32'hAAAA) begin failures++; $display("FAIL fwd_exm_b got=%h exp=0000aaaa", alu_b); end
      checks++; if (ex_store_data !== 32'hAAAA) begin failures++; $display("FAIL fwd_store got=%h exp=0000aaaa", ex_store_data); end
      exm_regwrite = 1'b0; mwb_regwrite = 1'b0;
   endtask

   task automatic test_load_use();
      clear_inputs();
      id_regwrite = 1'b1; id_memread = 1'b1; id_alusrc = 1'b1; id_regdst = 1'b0; id_rt = 5'd8;
      step();
      checks++; if (ex_memread !== 1'b1 || ex_dest !== 5'd8) begin failures++; $display("FAIL lw_ex got=%b/%0d exp=1/8", ex_memread, ex_dest); end
      id_memread = 1'b0; id_rs = 5'd3; id_rt = 5'd8; id_alusrc = 1'b0;
      #1;
      checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lus_rt got=%b exp=1", load_use_stall); end
      id_alusrc = 1'b1;
      #1;
      checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lus_rt_imm got=%b exp=0", load_use_stall); end
      id_rs = 5'd8;
      #1;
      checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lus_rs got=%b exp=1", load_use_stall); end
      id_valid = 1'b0;
      #1;
      checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lus_idinvalid got=%b exp=0", load_use_stall); end
   endtask

   task automatic test_stall_flush();
      clear_inputs();
      id_aluop = 2'b01; id_rs = 5'd1; id_rs_data = 32'h11; id_rt = 5'd2; id_rt_data = 32'h22;
      id_rd = 5'd9; id_regdst = 1'b1; id_regwrite = 1'b1;
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id_aluop = 2'b10; id_funct = 6'h24; id_rs_data = 32'hF0 + i; id_rt_data = 32'hE0 + i;
         id_rd = 5'd20 + 5'(i); id_regwrite = 1'b0; id_valid = i[0];
         step();
         checks++;
         if (ex_valid !== 1'b1 || alu_control !== 3'b110 || alu_a !== 32'h11 || alu_b !== 32'h22 ||
             ex_dest !== 5'd9 || ex_regwrite !== 1'b1 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold[%0d] got v=%b c=%b a=%h b=%h d=%0d rw=%b exp v=1 c=110 a=11 b=22 d=9 rw=1",
                     i, ex_valid, alu_control, alu_a, alu_b, ex_dest, ex_regwrite);
         end
      end
      flush = 1'b1;
      step();
      checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL stallflush_valid got=%b exp=0", ex_valid); end
      checks++; if (ex_regwrite !== 1'b0) begin failures++; $display("FAIL stallflush_rw got=%b exp=0", ex_regwrite); end
      checks++; if (alu_control !== 3'b110) begin failures++; $display("FAIL bubble_ctrl got=%b exp=110", alu_control); end
      stall = 1'b0; flush = 1'b0;
      id_valid = 1'b1; id_aluop = 2'b11; id_memread = 1'b1;
      step();
      checks++; if (illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_load got=%b exp=1", illegal_op); end
      flush = 1'b1;
      step();
      checks++; if (illegal_op !== 1'b0 || ex_memread !== 1'b0) begin failures++; $display("FAIL flush_clear got=%b/%b exp=0/0", illegal_op, ex_memread); end
      flush = 1'b0;
   endtask

   task automatic test_imm();
      clear_inputs();
      id_alusrc = 1'b1; id_imm = 32'hFFFFFFFC; id_rt = 5'd7; id_rt_data = 32'h77;
      step();
      checks++; if (alu_b !== 32'hFFFFFFFC) begin failures++; $display("FAIL imm_b got=%h exp=fffffffc", alu_b); end
      exm_regwrite = 1'b1; exm_rd = 5'd7; exm_result = 32'hDEAD;
      #1;
      checks++; if (alu_b !== 32'hFFFFFFFC) begin failures++; $display("FAIL imm_nofwd got=%h exp=fffffffc", alu_b); end
      checks++; if (ex_store_data !== 32'hDEAD) begin failures++; $display("FAIL imm_store got=%h exp=0000dead", ex_store_data); end
      exm_regwrite = 1'b0;
      #1;
      checks++; if (ex_store_data !== 32'h77) begin failures++; $display("FAIL imm_store_reg got=%h exp=00000077", ex_store_data); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_forwarding();
      test_load_use();
      test_stall_flush();
      test_imm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
